// File: rtl/rcs_pipe_sub.sv
// Two-stage pipelined ripple-borrow subtractor with a valid/ready handshake.
// The low half is resolved in stage 1; its borrow feeds the high half in stage 2.
module rcs_pipe_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             ovf_o
);

  localparam int unsigned H = WIDTH / 2;

  // R1: registered operands
  logic [WIDTH-1:0] a_q, b_q;
  logic             v1_q;
  // R2: low-half result plus the upper operand halves
  logic [H-1:0]     dlo_q, dlo_d;
  logic             bl_q, bl_d;
  logic [H-1:0]     ahi_q, bhi_q;
  logic             v2_q;
  // R3: final result
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             valid_q;

  logic             en;
  logic             br_lo, br_hi;
  logic [H-1:0]     dhi;

  // The whole pipe advances together unless a held result is being refused.
  assign en      = !valid_q || ready_i;
  assign ready_o = en;

  always_comb begin : stage1_sub
    br_lo = 1'b0;
    dlo_d = '0;
    for (int unsigned i = 0; i < H; i++) begin
      dlo_d[i] = a_q[i] ^ b_q[i] ^ br_lo;
      br_lo    = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br_lo);
    end
    bl_d = br_lo;
  end

  always_comb begin : stage2_sub
    br_hi = bl_q;
    dhi   = '0;
    for (int unsigned i = 0; i < H; i++) begin
      dhi[i] = ahi_q[i] ^ bhi_q[i] ^ br_hi;
      br_hi  = (~ahi_q[i] & bhi_q[i]) | (~(ahi_q[i] ^ bhi_q[i]) & br_hi);
    end
    diff_d   = {dhi, dlo_q};
    borrow_d = br_hi;
    // Signed overflow: operand signs differ and the result sign departs from the minuend's.
    ovf_d    = (ahi_q[H-1] != bhi_q[H-1]) && (dhi[H-1] != ahi_q[H-1]);
  end

  always_ff @(posedge clk) begin : pipe_regs
    if (!rstn) begin
      a_q      <= '0;
      b_q      <= '0;
      v1_q     <= 1'b0;
      dlo_q    <= '0;
      bl_q     <= 1'b0;
      ahi_q    <= '0;
      bhi_q    <= '0;
      v2_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else if (en) begin
      a_q      <= a_i;
      b_q      <= b_i;
      v1_q     <= valid_i;
      dlo_q    <= dlo_d;
      bl_q     <= bl_d;
      ahi_q    <= a_q[WIDTH-1:H];
      bhi_q    <= b_q[WIDTH-1:H];
      v2_q     <= v1_q;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      valid_q  <= v2_q;
    end
  end

  assign valid_o  = valid_q;
  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_rcs_pipe_sub.sv
// Randomized and directed bench for rcs_pipe_sub against a queue-based reference
// that treats the pipe as a fixed two-advance delay line.
module tb_rcs_pipe_sub;

  logic       clk = 1'b0;
  logic       rstn;
  logic       valid_i, ready_o, valid_o, ready_i;
  logic [7:0] a_i, b_i, diff_o;
  logic       borrow_o, ovf_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0] res;
    int         age;
  } ent_t;
  ent_t q[$];

  rcs_pipe_sub #(.WIDTH(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .diff_o   (diff_o),
    .borrow_o (borrow_o),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference result {diff, borrow, ovf} from plain integer arithmetic.
  function automatic logic [9:0] ref_res(input logic [7:0] a, input logic [7:0] b);
    int d, sa, sb, sd;
    logic [7:0] dm;
    d  = int'(a) - int'(b);
    dm = 8'((d + 256) % 256);
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    sd = sa - sb;
    return {dm, (d < 0), (sd < -128 || sd > 127)};
  endfunction

  // One clock cycle: drive, check against the model, update the model, advance.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
    logic exp_v, en;
    logic [9:0] h;
    valid_i = v;
    a_i     = a;
    b_i     = b;
    ready_i = r;
    #1;
    exp_v = (q.size() > 0) && (q[0].age >= 2);
    check_eq("valid_o", valid_o, exp_v);
    check_eq("ready_o", ready_o, !exp_v || r);
    if (exp_v) begin
      h = q[0].res;
      check_eq("diff_o", diff_o, h[9:2]);
      check_eq("borrow_o", borrow_o, h[1]);
      check_eq("ovf_o", ovf_o, h[0]);
    end
    en = !exp_v || r;
    if (!rstn) begin
      q.delete();
    end else begin
      if (exp_v && r) void'(q.pop_front());
      if (en) begin
        foreach (q[i]) q[i].age = q[i].age + 1;
        if (v) q.push_back('{res: ref_res(a, b), age: 0});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, valid_o, 1'b0);
    check_eq({tag, "_diff"}, diff_o, 8'h00);
    check_eq({tag, "_borrow"}, borrow_o, 1'b0);
    check_eq({tag, "_ovf"}, ovf_o, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check_zero("reset");

    // Directed vectors, including low-to-high borrow and signed overflow.
    cycle(1'b1, 8'hC8, 8'h37, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    check_eq("dir_c8_37_diff", diff_o, 8'h91);
    check_eq("dir_c8_37_valid", valid_o, 1'b1);
    cycle(1'b1, 8'h05, 8'h0A, 1'b1);
    cycle(1'b1, 8'h80, 8'h01, 1'b1);
    cycle(1'b1, 8'h00, 8'h00, 1'b1);
    check_eq("dir_05_0a_diff", diff_o, 8'hFB);
    check_eq("dir_05_0a_borrow", borrow_o, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    check_eq("dir_80_01_diff", diff_o, 8'h7F);
    check_eq("dir_80_01_ovf", ovf_o, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 8'h00, 1'b1);

    // Back-to-back stream, then the same with a one-slot bubble.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    for (int i = 0; i < 10; i++)
      cycle((i != 5), 8'($urandom), 8'($urandom), 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 8'h00, 1'b1);

    // Fill, stall for four cycles, then drain.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 8'h00, 1'b1);

    // Reset with three results in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    rstn = 1'b0;
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    rstn = 1'b1;
    check_zero("midrst");
    repeat (4) cycle(1'b0, 8'h00, 8'h00, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1);
    check_eq("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rcs_pipe_sub.md
Name: rcs_pipe_sub

Overview:
- Two-stage pipelined ripple-borrow subtractor: unsigned difference a_i - b_i with borrow and signed-overflow flags.
- Companion to the two-stage pipelined ripple-carry adder in the arithmetic datapath.
- Lower half is resolved in stage 1; its borrow is registered and consumed by the upper half in stage 2.
- Adds a valid/ready handshake so a consumer can stall the pipe.

Parameters:
- width, 8, operand width in bits; must be even and >= 2. Half width h = width/2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  synchronous active-low reset, sampled on the clk rising edge.
- valid_i  input  1  a_i/b_i carry a valid operand pair this cycle.
- ready_o  output  1  pipe accepts an operand pair this cycle.
- a_i  input  width  minuend, unsigned.
- b_i  input  width  subtrahend, unsigned.
- valid_o  output  1  diff_o/borrow_o/ovf_o hold a valid result.
- ready_i  input  1  downstream accepts the result this cycle.
- diff_o  output  width  (a - b) mod 2^width.
- borrow_o  output  1  1 when a < b, unsigned.
- ovf_o  output  1  signed two's-complement overflow of a - b.

Behaviour:
- Reset: rstn=0 at a clk edge clears all pipeline data registers and valid bits to 0. diff_o=0, borrow_o=0, ovf_o=0, valid_o=0.
- Reset mid-operation: in-flight results are discarded; no valid_o pulse follows reset.
- Pipeline registers:
  - R1 (input): a, b, v1.
  - R2 (mid): low-half diff, low-half borrow, a/b upper halves, v2.
  - R3 (output): diff, borrow, ovf, valid.
- Stage 1 (R1 -> R2): d[h-1:0] = a[h-1:0] - b[h-1:0] via ripple-borrow full subtractors, borrow-in 0. bl = borrow out of bit h-1.
- Stage 2 (R2 -> R3):
  - d[width-1:h] = a_hi - b_hi - bl, ripple-borrow.
  - borrow = borrow out of the MSB.
  - ovf = (a[msb] != b[msb]) && (d[msb] != a[msb]).
- Global advance: en = !valid_o || ready_i. ready_o = en (combinational).
- When en=1, all of R1, R2, R3 load together:
  - v1 <= valid_i, v2 <= v1, valid_o <= v2.
  - Data registers load regardless of the valid bit.
- When en=0, every register holds. Outputs stay stable while valid_o=1 and ready_i=0.
- Latency: an operand pair accepted at edge k (valid_i && ready_o) gives valid_o=1 after edge k+2 and is visible in cycle k+2. That is three register stages, matching the adder.
- Throughput: one result per cycle when ready_i is held 1. Bubbles (valid_i=0) propagate as valid=0 slots.
- Transfers:
  - Result transfer occurs on an edge with valid_o && ready_i.
  - valid_o=0 with ready_i=0 does not stall; bubbles are squeezed out.
- Simultaneous events: reset has priority over en. A transfer and a new acceptance on the same edge both complete.
- Wrap-around: results are modulo 2^width. No saturation.

Test Plan:
- width=8, a=0xC8(200), b=0x37(55), ready_i=1 -> valid_o 2 cycles after acceptance; diff_o=0x91, borrow_o=0, ovf_o=0.
- a=0x05, b=0x0A -> diff_o=0xFB, borrow_o=1, ovf_o=0. Checks borrow crossing from the low half into the high half.
- a=0x80, b=0x01 -> diff_o=0x7F, borrow_o=0, ovf_o=1. Then a=0x00, b=0x00 -> diff_o=0x00, all flags 0.
- Stream 10 random pairs back-to-back with ready_i=1 -> 10 consecutive valid_o cycles, in order, each matching (a-b) mod 256. Repeat with a valid_i=0 gap -> one-slot gap in valid_o.
- Fill the pipe, then drop ready_i for 4 cycles:
  - ready_o=0 throughout.
  - diff_o and valid_o stay frozen.
  - On re-assert, the three held results drain in order with no loss or duplication.
- Pull rstn=0 for one edge with 3 results in flight -> next cycle valid_o=0, diff_o=0, borrow_o=0, ovf_o=0. No stale result appears afterwards.
